// File: rtl/led_arb_pkg.sv
// Shared types and round-robin picker for the LED bank arbiter.
package led_arb_pkg;

  localparam int unsigned LED_W   = 4;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First set bit scanning upward from ptr+1, wrapping. Callers zero-fill
  // unused request bits, so wrapping at MAX_REQ matches wrapping at NREQ.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input logic [IDX_W-1:0]   ptr);
    pick_t            p;
    logic [IDX_W-1:0] c;
    p = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      c = ptr + IDX_W'(k);
      if (!p.valid && req[c]) begin
        p.valid = 1'b1;
        p.idx   = c;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink half-period prescaler and phase flop; restart forces phase on, count 0.
module blink_timer #(
  parameter int unsigned BLINK_HALF = 10_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic restart_i,
  output logic phase_nxt_o
);

  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart_i) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (en_i) begin
      if (cnt_q == BW'(BLINK_HALF - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Registered LED output needs the phase that will hold after this edge.
  assign phase_nxt_o = phase_d;

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin time-sharing of the LED bank between NREQ requesters.
// Define LED_ARB_FIXED_PRIO_EN for fixed lowest-index priority with preemption.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DWELL      = 10_000_000,
  parameter int unsigned BLINK_HALF = 10_000_000
) (
  input  logic                  clck,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [LED_W*NREQ-1:0] pattern,
  input  logic [NREQ-1:0]       blink,
  output logic [NREQ-1:0]       grant,
  output logic [LED_W-1:0]      led,
  output logic                  busy
);

  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [LED_W-1:0]   pat_q, pat_d;
  logic               blk_q, blk_d;
  logic [DW-1:0]      dwell_q, dwell_d;

  logic [MAX_REQ-1:0] req_ext;
  pick_t              pick;
  logic [LED_W-1:0]   sel_pat;
  logic               sel_blk;
  logic               slot_end;
  logic               arbitrate;
  logic               restart;
  logic               phase_nxt;

  blink_timer #(.BLINK_HALF(BLINK_HALF)) u_blink_timer (
    .clk_i       (clck),
    .rst_ni      (reset),
    .en_i        (state_q == SHOW),
    .restart_i   (restart),
    .phase_nxt_o (phase_nxt)
  );

  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req;
    pick                = rr_pick(req_ext, ptr_q);
    sel_pat             = '0;
    sel_blk             = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick.idx == IDX_W'(i)) begin
        sel_pat = pattern[LED_W*i +: LED_W];
        sel_blk = blink[i];
      end
    end
  end

`ifdef LED_ARB_FIXED_PRIO_EN
  // grant_q is one-hot in SHOW, so grant_q-1 masks every lower index.
  assign slot_end = (dwell_q == DW'(DWELL - 1)) || !(|(req & grant_q)) ||
                    (|(req & (grant_q - NREQ'(1))));
`else
  assign slot_end = (dwell_q == DW'(DWELL - 1)) || !(|(req & grant_q));
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    led_d     = led_q;
    pat_d     = pat_q;
    blk_d     = blk_q;
    dwell_d   = dwell_q;
    restart   = 1'b0;
    arbitrate = 1'b0;

    case (state_q)
      IDLE: arbitrate = 1'b1;
      SHOW: begin
        if (slot_end) begin
          arbitrate = 1'b1;
        end else begin
          dwell_d = dwell_q + 1'b1;
          led_d   = blk_q ? (pat_q & {LED_W{phase_nxt}}) : pat_q;
        end
      end
      default: arbitrate = 1'b1;
    endcase

    if (arbitrate) begin
      dwell_d = '0;
      if (pick.valid) begin
        state_d = SHOW;
        grant_d = NREQ'(1) << pick.idx;
`ifndef LED_ARB_FIXED_PRIO_EN
        ptr_d   = pick.idx;
`endif
        pat_d   = sel_pat;
        blk_d   = sel_blk;
        led_d   = sel_pat;
        restart = 1'b1;
      end else begin
        state_d = IDLE;
        grant_d = '0;
        led_d   = '0;
      end
    end
  end

  // Fixed-priority builds keep the pointer at NREQ-1, so the scan starts at 0.
  always_ff @(posedge clck or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NREQ - 1);
      grant_q <= '0;
      led_q   <= '0;
      pat_q   <= '0;
      blk_q   <= 1'b0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      led_q   <= led_d;
      pat_q   <= pat_d;
      blk_q   <= blk_d;
      dwell_q <= dwell_d;
    end
  end

  assign grant = grant_q;
  assign led   = led_q;
  assign busy  = (state_q == SHOW);

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter (NREQ=4, DWELL=8, BLINK_HALF=2).
module tb_led_bank_arbiter;

  logic        clck;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] pattern;
  logic [3:0]  blink;
  logic [3:0]  grant;
  logic [3:0]  led;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  led_bank_arbiter #(.NREQ(4), .DWELL(8), .BLINK_HALF(2)) dut (
    .clck    (clck),
    .reset   (reset),
    .req     (req),
    .pattern (pattern),
    .blink   (blink),
    .grant   (grant),
    .led     (led),
    .busy    (busy)
  );

  initial clck = 1'b0;
  always #5 clck = ~clck;

  typedef struct {
    logic [3:0] g;
    logic [3:0] l;
    logic       b;
    string      name;
  } exp_t;

  typedef struct {
    logic [3:0]  rq;
    logic [15:0] pt;
    logic [3:0]  bk;
    logic [3:0]  g;
    logic [3:0]  l;
    logic        b;
    string       name;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[$];

  task automatic push(input logic [3:0] g, input logic [3:0] l, input logic b,
                      input string n);
    exp_t e;
    e.g = g; e.l = l; e.b = b; e.name = n;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_chk++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: no expected value for grant=%b led=%h busy=%b",
               grant, led, busy);
    end else begin
      e = sbq.pop_front();
      if (grant !== e.g || led !== e.l || busy !== e.b) begin
        n_fail++;
        $display("FAIL %s @%0t: got grant=%b led=%h busy=%b, need grant=%b led=%h busy=%b",
                 e.name, $time, grant, led, busy, e.g, e.l, e.b);
      end
    end
  endtask

  task automatic add(input logic [3:0] rq, input logic [15:0] pt, input logic [3:0] bk,
                     input logic [3:0] g, input logic [3:0] l, input logic b,
                     input string n);
    vec_t v;
    v.rq = rq; v.pt = pt; v.bk = bk; v.g = g; v.l = l; v.b = b; v.name = n;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clck);
    #2;
  endtask

  logic [3:0] rr_g[4];
  logic [3:0] rr_l[4];

  initial begin
    rr_g = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    rr_l = '{4'h3, 4'h5, 4'h9, 4'h3};

    reset   = 1'b0;
    req     = 4'hF;
    pattern = 16'h9653;
    blink   = 4'b0000;

    // Held in reset with every requester asking: outputs stay dark.
    for (int i = 0; i < 3; i++) begin
      push(4'b0000, 4'h0, 1'b0, "reset_hold");
      tick();
      pop_check();
    end

`ifdef LED_ARB_FIXED_PRIO_EN
    reset = 1'b1;
    req   = 4'b0100;
    pattern = 16'h4321;
    for (int i = 0; i < 2; i++) begin
      push(4'b0100, 4'h3, 1'b1, "fixed_req2");
      tick();
      pop_check();
    end
    req = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      push(4'b0001, 4'h1, 1'b1, "fixed_preempt");
      tick();
      pop_check();
    end
    req = 4'b0000;
    push(4'b0000, 4'h0, 1'b0, "fixed_idle");
    tick();
    pop_check();
`else
    // Round-robin over 0,1,3 with back-to-back slots of exactly 8 cycles.
    req   = 4'b1011;
    reset = 1'b1;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 8; c++)
        push(rr_g[s], rr_l[s], 1'b1, "round_robin");
    for (int i = 0; i < 32; i++) begin
      tick();
      pop_check();
    end
    req = 4'b0000;
    push(4'b0000, 4'h0, 1'b0, "rr_to_idle");
    tick();
    pop_check();

    // Pattern hold: latched at grant, new value only at the re-grant.
    add(4'b0001, 16'h0003, 4'b0000, 4'b0001, 4'h3, 1'b1, "pattern_hold");
    for (int i = 1; i < 8; i++)
      add(4'b0001, 16'h000C, 4'b0000, 4'b0001, 4'h3, 1'b1, "pattern_hold");
    add(4'b0001, 16'h000C, 4'b0000, 4'b0001, 4'hC, 1'b1, "pattern_relatch");
    add(4'b0000, 16'h000C, 4'b0000, 4'b0000, 4'h0, 1'b0, "hold_drop_idle");

    // Blink: on 2, off 2, phase restarted by the re-grant after 8 cycles.
    for (int i = 0; i < 11; i++)
      add(4'b0100, 16'h0A00, 4'b0100, 4'b0100, ((i % 4) < 2) ? 4'hA : 4'h0, 1'b1, "blink");
    add(4'b0000, 16'h0A00, 4'b0100, 4'b0000, 4'h0, 1'b0, "blink_drop_idle");

    // Abandon: req[1] drops during slot cycle 3, requester 3 takes over next edge.
    for (int i = 0; i < 4; i++)
      add(4'b0010, 16'h9050, 4'b0000, 4'b0010, 4'h5, 1'b1, "abandon_show");
    add(4'b1000, 16'h9050, 4'b0000, 4'b1000, 4'h9, 1'b1, "abandon_next");
    add(4'b0000, 16'h9050, 4'b0000, 4'b0000, 4'h0, 1'b0, "abandon_idle");

    foreach (tbl[k]) begin
      req     = tbl[k].rq;
      pattern = tbl[k].pt;
      blink   = tbl[k].bk;
      push(tbl[k].g, tbl[k].l, tbl[k].b, tbl[k].name);
      tick();
      pop_check();
    end

    // Async reset mid-slot, then arbitration restarts from requester 0.
    req     = 4'b0110;
    pattern = 16'h4321;
    blink   = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      push(4'b0010, 4'h2, 1'b1, "pre_reset_slot");
      tick();
      pop_check();
    end
    #1;
    reset = 1'b0;
    #1;
    push(4'b0000, 4'h0, 1'b0, "async_reset_clear");
    pop_check();
    req   = 4'b0111;
    #1;
    reset = 1'b1;
    push(4'b0001, 4'h1, 1'b1, "reset_restart_req0");
    tick();
    pop_check();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
